// File: rtl/pattern_stream_source_if.sv
// Bus between the pattern stream source and its environment: segment program port,
// playback control, the played/predicted pattern pair and the score counters.
interface pattern_stream_source_if #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
) ();
  localparam int AW = $clog2(DEPTH);

  logic             seg_wr_en;
  logic [AW-1:0]    seg_wr_addr;
  logic             seg_level;
  logic [LEN_W-1:0] seg_len;
  logic [AW:0]      num_segs;
  logic             start;
  logic             predicted_pattern;
  logic             actual_pattern;
  logic             pattern_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic [CNT_W-1:0] max_miss_run;
  logic [CNT_W-1:0] cyc_cnt;

  modport master (
    input  seg_wr_en, seg_wr_addr, seg_level, seg_len, num_segs, start, predicted_pattern,
    output actual_pattern, pattern_valid, busy, done, hit_cnt, miss_cnt, max_miss_run, cyc_cnt
  );

  modport slave (
    output seg_wr_en, seg_wr_addr, seg_level, seg_len, num_segs, start, predicted_pattern,
    input  actual_pattern, pattern_valid, busy, done, hit_cnt, miss_cnt, max_miss_run, cyc_cnt
  );
endinterface

// File: rtl/pattern_stream_source.sv
// Plays a programmed run-length sequence of 0/1 levels onto actual_pattern and scores
// the predictor's predicted_pattern against it with saturating hit/miss/streak counters.
module pattern_stream_source #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  pattern_stream_source_if.master bus
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_N = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  logic             mem_level_q [DEPTH];
  logic [LEN_W-1:0] mem_len_q   [DEPTH];

  state_t           state_q, state_d;
  logic [AW-1:0]    seg_idx_q, seg_idx_d;
  logic [AW-1:0]    last_q, last_d;
  logic [AW-1:0]    seg_nxt;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             act_q, act_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [AW:0]      nsegs_clamped;
  logic             wr_ok;
  logic             miss_now;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] max_u(input logic [CNT_W-1:0] a,
                                             input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] l);
    return (l == '0) ? LEN_W'(1) : l;
  endfunction

  always_comb begin
    state_d       = state_q;
    seg_idx_d     = seg_idx_q;
    last_d        = last_q;
    rem_d         = rem_q;
    act_d         = act_q;
    vld_d         = vld_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    hit_d         = hit_q;
    miss_d        = miss_q;
    max_d         = max_q;
    cyc_d         = cyc_q;
    run_d         = run_q;
    wr_ok         = 1'b0;
    seg_nxt       = seg_idx_q + AW'(1);
    nsegs_clamped = (bus.num_segs > DEPTH_N) ? DEPTH_N : bus.num_segs;
    miss_now      = bus.predicted_pattern ^ act_q;

    case (state_q)
      PLAY: begin
        cyc_d = sat_inc(cyc_q);
        if (miss_now) begin
          miss_d = sat_inc(miss_q);
          run_d  = sat_inc(run_q);
          max_d  = max_u(max_q, sat_inc(run_q));
        end else begin
          hit_d = sat_inc(hit_q);
          run_d = '0;
        end

        // Last cycle of a segment: chain straight into the next one, or finish.
        if (rem_q == LEN_W'(1)) begin
          if (seg_idx_q == last_q) begin
            state_d = DONE;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
            act_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            seg_idx_d = seg_nxt;
            rem_d     = eff_len(mem_len_q[seg_nxt]);
            act_d     = mem_level_q[seg_nxt];
          end
        end else begin
          rem_d = rem_q - LEN_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
        act_d   = 1'b0;
        // A write racing an accepted start is dropped so the run sees a stable program.
        wr_ok   = bus.seg_wr_en && !bus.start;
        if (bus.start) begin
          hit_d  = '0;
          miss_d = '0;
          max_d  = '0;
          cyc_d  = '0;
          run_d  = '0;
          if (bus.num_segs == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = PLAY;
            seg_idx_d = '0;
            last_d    = AW'(nsegs_clamped - 1'b1);
            rem_d     = eff_len(mem_len_q[0]);
            act_d     = mem_level_q[0];
            vld_d     = 1'b1;
            busy_d    = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      seg_idx_q <= '0;
      last_q    <= '0;
      rem_q     <= '0;
      act_q     <= 1'b0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hit_q     <= '0;
      miss_q    <= '0;
      max_q     <= '0;
      cyc_q     <= '0;
      run_q     <= '0;
    end else begin
      state_q   <= state_d;
      seg_idx_q <= seg_idx_d;
      last_q    <= last_d;
      rem_q     <= rem_d;
      act_q     <= act_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      max_q     <= max_d;
      cyc_q     <= cyc_d;
      run_q     <= run_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_level_q[bus.seg_wr_addr] <= bus.seg_level;
      mem_len_q[bus.seg_wr_addr]   <= bus.seg_len;
    end
  end

  assign bus.actual_pattern = act_q;
  assign bus.pattern_valid  = vld_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.hit_cnt        = hit_q;
  assign bus.miss_cnt       = miss_q;
  assign bus.max_miss_run   = max_q;
  assign bus.cyc_cnt        = cyc_q;

endmodule

// File: doc/pattern_stream_source.md
Name: pattern_stream_source

Overview:
- Drives the actual-pattern side of the pattern predictor interface: plays a programmable run-length sequence of 0/1 levels onto actual_pattern.
- Samples the predictor's predicted_pattern on every played cycle and scores it against the bit it drove: hits, misses, longest miss streak and played cycles.
- Sits opposite the 2-bit predictor FSM, replacing hand-timed stimulus with a reusable, self-scoring source.

Parameters:
- DEPTH, 8, number of segment slots in the program memory
- LEN_W, 8, width of each segment's run length
- CNT_W, 8, width of all score counters (saturating)

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- seg_wr_en  in  1  program-write strobe
- seg_wr_addr  in  $clog2(DEPTH)  slot to write
- seg_level  in  1  level driven for the segment
- seg_len  in  LEN_W  run length in cycles; 0 is treated as 1
- num_segs  in  $clog2(DEPTH)+1  segments to play, sampled when start is accepted
- start  in  1  begin playback (single-cycle pulse)
- predicted_pattern  in  1  predictor output for the current cycle
- actual_pattern  out  1  played bit, registered
- pattern_valid  out  1  actual_pattern is a played bit this cycle
- busy  out  1  high while in PLAY
- done  out  1  one-cycle pulse when playback ends
- hit_cnt  out  CNT_W  cycles where predicted_pattern == actual_pattern
- miss_cnt  out  CNT_W  cycles where they differ
- max_miss_run  out  CNT_W  longest run of consecutive misses
- cyc_cnt  out  CNT_W  played cycles

Behaviour:

Reset:
- Takes effect at the next edge.
- All outputs go to 0 and state goes to IDLE.
- Program memory is not cleared.
- Reset mid-PLAY aborts playback with no done pulse.

Program writes:
- Accepted only in IDLE or DONE; ignored in PLAY.
- A write to slot i in the same cycle as an accepted start is not seen by that playback.

State IDLE:
- start with num_segs >= 1 (values above DEPTH are clamped to DEPTH) goes to PLAY.
- On acceptance: hit_cnt, miss_cnt, max_miss_run, cyc_cnt and the internal miss-run counter clear; the segment index and the remaining-length counter load from slot 0.
- start with num_segs == 0 goes to DONE and clears the counters; done pulses on the next cycle.

State PLAY:
- The first pattern_valid=1 cycle is the cycle after start is sampled.
- Segment k drives seg_level[k] for max(seg_len[k],1) consecutive cycles.
- Segments follow back-to-back with no bubble.
- busy=1 and pattern_valid=1 throughout PLAY.
- After the last cycle of segment num_segs-1, go to DONE.

State DONE:
- Lasts one cycle: done=1, pattern_valid=0, busy=0; then goes to IDLE.
- Counters hold their values until the next accepted start.
- start in DONE is accepted exactly as in IDLE, so back-to-back runs are possible.
- start while in PLAY is ignored.

Scoring, for every cycle with pattern_valid=1:
- Compare predicted_pattern (same cycle) to actual_pattern.
- Counter updates are registered and visible one cycle later; the final values are stable in the done cycle.
- cyc_cnt increments every valid cycle.
- On a hit: hit_cnt increments and the miss-run counter clears.
- On a miss: miss_cnt and the miss-run counter increment; max_miss_run = max(max_miss_run, new run).
- All counters saturate at 2^CNT_W-1 and never wrap.

Timing:
- Total playback cycles = sum of max(seg_len,1) over the played segments.
- Total latency from start to done = that sum + 1 cycles.

Test Plan:
- Program segments (0,3),(1,8),(0,4),(1,4),(0,8),(1,4),(0,4), num_segs=7, predicted_pattern tied 0 -> 35 valid cycles; done 36 cycles after start; hit=19, miss=16, max_miss_run=8, cyc=35.
- Same program, predicted_pattern tied 1 -> hit=16, miss=19, max_miss_run=8; actual_pattern sequence checked bit-exact against the program.
- CNT_W=4, single segment (1,20), predicted 0 -> miss_cnt=15, max_miss_run=15, cyc_cnt=15, hit_cnt=0 (saturation, no wrap).
- num_segs=0 -> done pulses the cycle after start; pattern_valid never asserts; all counters 0. Segment with seg_len=0 plays exactly 1 cycle.
- Assert reset 5 cycles into PLAY -> next cycle all outputs 0, IDLE, no done pulse. A following start replays from slot 0 with the program intact.
- seg_wr_en and start pulses during PLAY -> ignored: played bits and slot contents unchanged. start in the DONE cycle -> new playback begins the next cycle.
